// File: rtl/wshb_arbiter.sv
// Round-robin Wishbone arbiter sharing one SDRAM master port between the vga reader
// and the mire writer, with bounded-burst preemption when the other side is waiting.
module wshb_arbiter #(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst,
  // requester 0: vga reader
  input  logic        vga_cyc,
  input  logic        vga_stb,
  input  logic        vga_we,
  input  logic [31:0] vga_adr,
  input  logic [3:0]  vga_sel,
  input  logic [31:0] vga_dat_ms,
  input  logic [2:0]  vga_cti,
  input  logic [1:0]  vga_bte,
  output logic [31:0] vga_dat_sm,
  output logic        vga_ack,
  output logic        vga_err,
  output logic        vga_rty,
  // requester 1: mire writer
  input  logic        mire_cyc,
  input  logic        mire_stb,
  input  logic        mire_we,
  input  logic [31:0] mire_adr,
  input  logic [3:0]  mire_sel,
  input  logic [31:0] mire_dat_ms,
  input  logic [2:0]  mire_cti,
  input  logic [1:0]  mire_bte,
  output logic [31:0] mire_dat_sm,
  output logic        mire_ack,
  output logic        mire_err,
  output logic        mire_rty,
  // shared port toward the SDRAM controller
  output logic        ifm_cyc,
  output logic        ifm_stb,
  output logic        ifm_we,
  output logic [31:0] ifm_adr,
  output logic [3:0]  ifm_sel,
  output logic [31:0] ifm_dat_ms,
  output logic [2:0]  ifm_cti,
  output logic [1:0]  ifm_bte,
  input  logic [31:0] ifm_dat_sm,
  input  logic        ifm_ack,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, GNT_VGA, GNT_MIRE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BEATS - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] beats;
  logic                 last;

  // last = 1 after reset so vga wins the first tie
  always_ff @(posedge wshb_clk) begin
    if (wshb_rst) begin
      state <= IDLE;
      grant <= 2'b00;
      beats <= '0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (vga_cyc && (!mire_cyc || last)) begin
            state <= GNT_VGA;
            grant <= 2'b01;
            beats <= '0;
            last  <= 1'b0;
          end else if (mire_cyc) begin
            state <= GNT_MIRE;
            grant <= 2'b10;
            beats <= '0;
            last  <= 1'b1;
          end
        end
        GNT_VGA: begin
          if (!vga_cyc || (ifm_ack && beats == LAST_BEAT && mire_cyc)) begin
            if (mire_cyc) begin
              state <= GNT_MIRE;
              grant <= 2'b10;
              beats <= '0;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end else if (ifm_ack) begin
            beats <= (beats == LAST_BEAT) ? '0 : beats + CNT_WIDTH'(1);
          end
        end
        GNT_MIRE: begin
          if (!mire_cyc || (ifm_ack && beats == LAST_BEAT && vga_cyc)) begin
            if (vga_cyc) begin
              state <= GNT_VGA;
              grant <= 2'b01;
              beats <= '0;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end else if (ifm_ack) begin
            beats <= (beats == LAST_BEAT) ? '0 : beats + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Forward mux selected by the registered owner
  always_comb begin
    ifm_cyc    = 1'b0;
    ifm_stb    = 1'b0;
    ifm_we     = 1'b0;
    ifm_adr    = '0;
    ifm_sel    = '0;
    ifm_dat_ms = '0;
    ifm_cti    = '0;
    ifm_bte    = '0;
    case (state)
      GNT_VGA: begin
        ifm_cyc    = vga_cyc;
        ifm_stb    = vga_stb;
        ifm_we     = vga_we;
        ifm_adr    = vga_adr;
        ifm_sel    = vga_sel;
        ifm_dat_ms = vga_dat_ms;
        ifm_cti    = vga_cti;
        ifm_bte    = vga_bte;
      end
      GNT_MIRE: begin
        ifm_cyc    = mire_cyc;
        ifm_stb    = mire_stb;
        ifm_we     = mire_we;
        ifm_adr    = mire_adr;
        ifm_sel    = mire_sel;
        ifm_dat_ms = mire_dat_ms;
        ifm_cti    = mire_cti;
        ifm_bte    = mire_bte;
      end
      default: ;
    endcase
  end

  assign vga_dat_sm  = ifm_dat_sm;
  assign mire_dat_sm = ifm_dat_sm;
  assign vga_ack     = (state == GNT_VGA) && ifm_ack;
  assign mire_ack    = (state == GNT_MIRE) && ifm_ack;
  assign vga_err     = 1'b0;
  assign vga_rty     = 1'b0;
  assign mire_err    = 1'b0;
  assign mire_rty    = 1'b0;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Randomized and directed checks of wshb_arbiter against an owner/turn-count reference model.
module tb_wshb_arbiter;

  localparam int unsigned MAX = 4;

  logic        clk = 1'b0;
  logic        wshb_rst = 1'b1;
  logic        vga_cyc = 1'b0, vga_stb = 1'b0, vga_we = 1'b0;
  logic [31:0] vga_adr = 32'h1000_0000, vga_dat_ms = 32'h0;
  logic [3:0]  vga_sel = 4'hf;
  logic [2:0]  vga_cti = 3'b010;
  logic [1:0]  vga_bte = 2'b01;
  logic        mire_cyc = 1'b0, mire_stb = 1'b0, mire_we = 1'b1;
  logic [31:0] mire_adr = 32'h2000_0000, mire_dat_ms = 32'h0;
  logic [3:0]  mire_sel = 4'hf;
  logic [2:0]  mire_cti = 3'b111;
  logic [1:0]  mire_bte = 2'b10;
  logic [31:0] vga_dat_sm, mire_dat_sm;
  logic        vga_ack, vga_err, vga_rty, mire_ack, mire_err, mire_rty;
  logic        ifm_cyc, ifm_stb, ifm_we;
  logic [31:0] ifm_adr, ifm_dat_ms;
  logic [3:0]  ifm_sel;
  logic [2:0]  ifm_cti;
  logic [1:0]  ifm_bte;
  logic [31:0] ifm_dat_sm = 32'h0;
  logic        ifm_ack = 1'b0;
  logic [1:0]  grant;

  wshb_arbiter #(.MAX_BEATS(MAX)) dut (
    .wshb_clk(clk), .wshb_rst(wshb_rst),
    .vga_cyc(vga_cyc), .vga_stb(vga_stb), .vga_we(vga_we), .vga_adr(vga_adr),
    .vga_sel(vga_sel), .vga_dat_ms(vga_dat_ms), .vga_cti(vga_cti), .vga_bte(vga_bte),
    .vga_dat_sm(vga_dat_sm), .vga_ack(vga_ack), .vga_err(vga_err), .vga_rty(vga_rty),
    .mire_cyc(mire_cyc), .mire_stb(mire_stb), .mire_we(mire_we), .mire_adr(mire_adr),
    .mire_sel(mire_sel), .mire_dat_ms(mire_dat_ms), .mire_cti(mire_cti), .mire_bte(mire_bte),
    .mire_dat_sm(mire_dat_sm), .mire_ack(mire_ack), .mire_err(mire_err), .mire_rty(mire_rty),
    .ifm_cyc(ifm_cyc), .ifm_stb(ifm_stb), .ifm_we(ifm_we), .ifm_adr(ifm_adr),
    .ifm_sel(ifm_sel), .ifm_dat_ms(ifm_dat_ms), .ifm_cti(ifm_cti), .ifm_bte(ifm_bte),
    .ifm_dat_sm(ifm_dat_sm), .ifm_ack(ifm_ack), .grant(grant)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: owner 0 = none, 1 = vga, 2 = mire; turn counts acks since grant
  int m_owner = 0;
  int m_turn  = 0;
  int m_last  = 1;

  int  obs_v_acks = 0;
  int  obs_m_acks = 0;
  bit  pend_v = 1'b0;
  bit  pend_m = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic give_to(input int k);
    m_owner = k;
    m_turn  = 0;
    m_last  = k - 1;
  endtask

  task automatic model_update(input bit v, input bit m, input bit ack);
    bit own, oth;
    if (m_owner == 0) begin
      if (v && m) give_to((m_last == 1) ? 1 : 2);
      else if (v) give_to(1);
      else if (m) give_to(2);
    end else begin
      own = (m_owner == 1) ? v : m;
      oth = (m_owner == 1) ? m : v;
      if (!own) begin
        if (oth) give_to(3 - m_owner);
        else m_owner = 0;
      end else if (ack) begin
        m_turn++;
        if ((m_turn % MAX) == 0 && oth) give_to(3 - m_owner);
      end
    end
  endtask

  // One clock cycle: drive at negedge, check combinational/registered outputs, advance model
  task automatic step(input bit v, input bit m, input bit a, input bit r);
    bit          e_stb;
    logic [11:0] e_ctl;
    logic [31:0] e_adr, e_dat;
    logic [1:0]  e_gnt;
    @(negedge clk);
    if (pend_v) begin
      vga_adr = vga_adr + 32'd4; vga_dat_ms = $urandom; vga_sel = 4'($urandom);
    end
    if (pend_m) begin
      mire_adr = mire_adr + 32'd4; mire_dat_ms = $urandom; mire_sel = 4'($urandom);
    end
    wshb_rst = r;
    vga_cyc = v;  vga_stb = v;
    mire_cyc = m; mire_stb = m;
    e_stb = (m_owner == 1) ? v : (m_owner == 2) ? m : 1'b0;
    ifm_ack = a && e_stb;
    ifm_dat_sm = $urandom;
    #1;
    case (m_owner)
      1: begin
        e_ctl = {v, v, vga_we, vga_sel, vga_cti, vga_bte};
        e_adr = vga_adr; e_dat = vga_dat_ms; e_gnt = 2'b01;
      end
      2: begin
        e_ctl = {m, m, mire_we, mire_sel, mire_cti, mire_bte};
        e_adr = mire_adr; e_dat = mire_dat_ms; e_gnt = 2'b10;
      end
      default: begin
        e_ctl = '0; e_adr = '0; e_dat = '0; e_gnt = 2'b00;
      end
    endcase
    check_val("grant", 32'(grant), 32'(e_gnt));
    check_val("ifm_ctl", 32'({ifm_cyc, ifm_stb, ifm_we, ifm_sel, ifm_cti, ifm_bte}), 32'(e_ctl));
    check_val("ifm_adr", ifm_adr, e_adr);
    check_val("ifm_dat_ms", ifm_dat_ms, e_dat);
    check_val("acks", 32'({vga_ack, mire_ack}),
              32'({(m_owner == 1) && ifm_ack, (m_owner == 2) && ifm_ack}));
    check_val("vga_dat_sm", vga_dat_sm, ifm_dat_sm);
    check_val("mire_dat_sm", mire_dat_sm, ifm_dat_sm);
    check_val("err_rty", 32'({vga_err, vga_rty, mire_err, mire_rty}), 32'h0);
    if (vga_ack === 1'b1) obs_v_acks++;
    if (mire_ack === 1'b1) obs_m_acks++;
    pend_v = (m_owner == 1) && ifm_ack;
    pend_m = (m_owner == 2) && ifm_ack;
    if (r) begin
      m_owner = 0; m_turn = 0; m_last = 1;
    end else begin
      model_update(v, m, ifm_ack);
    end
  endtask

  initial begin
    int         guard;
    int         turn_cnt;
    logic [1:0] prev_gnt;
    bit         v_r, m_r, a_r, r_r;

    // Reset, then vga alone for 100 beats
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    obs_v_acks = 0; obs_m_acks = 0;
    guard = 0;
    while (obs_v_acks < 100 && guard < 300) begin
      step(1, 0, 1, 0);
      guard++;
    end
    check_val("vga_beats", 32'(obs_v_acks), 32'd100);
    check_val("mire_no_ack", 32'(obs_m_acks), 32'd0);

    // Simultaneous first request after reset, then continuous contention
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    check_val("tie_first", 32'(grant), 32'h1);
    prev_gnt = grant;
    turn_cnt = (vga_ack === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 1, 0);
      check_val("no_idle", 32'(grant == 2'b00), 32'd0);
      if (grant != prev_gnt) begin
        check_val("turn_acks", 32'(turn_cnt), 32'(MAX));
        turn_cnt = 0;
        prev_gnt = grant;
      end
      if (vga_ack === 1'b1 || mire_ack === 1'b1) turn_cnt++;
    end

    // mire alone: grant held while beats wrap
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    obs_m_acks = 0;
    guard = 0;
    while (obs_m_acks < 10 && guard < 40) begin
      step(0, 1, 1, 0);
      check_val("mire_hold", 32'(grant), 32'h2);
      guard++;
    end
    check_val("mire_beats", 32'(obs_m_acks), 32'd10);

    // Early release by mire while vga waits
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    obs_m_acks = 0;
    guard = 0;
    while (obs_m_acks < 2 && guard < 20) begin
      step(1, 1, 1, 0);
      guard++;
    end
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    check_val("release_grant", 32'(grant), 32'h1);
    check_val("release_adr", ifm_adr, vga_adr);

    // Reset mid-burst with vga owning; tie afterwards must go to vga again
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    step(1, 1, 1, 0);
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_cyc", 32'(ifm_cyc), 32'h0);
    check_val("rst_acks", 32'({vga_ack, mire_ack}), 32'h0);
    step(1, 1, 1, 0);
    check_val("rst_tie", 32'(grant), 32'h1);

    // Random traffic with occasional resets
    v_r = 1'b0; m_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) v_r = !v_r;
      if ($urandom_range(7) == 0) m_r = !m_r;
      a_r = ($urandom_range(3) != 0);
      r_r = ($urandom_range(199) == 0);
      step(v_r, m_r, a_r, r_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
